// File: rtl/can_tx_mailbox_sched_if.sv
// ---------------------------------------------------------------------------
// can_tx_mailbox_sched_if
// Bundles the host mailbox-write port, the per-mailbox abort and status
// vectors, and the start/done handshake to can_transmitter.
//   master : host / transmitter side (drives writes, aborts, bus status,
//            handshake pulses; observes frame fields and status pulses)
//   slave  : the scheduler itself
// Signals:
//   mb_wr_en/idx/ide/id_std/id_ext/rtr/dlc/data : mailbox load port
//   mb_abort                                    : per-mailbox abort level
//   bus_idle, tx_done, tx_arb_lost, tx_error    : transmitter status
//   tx_start, tx_* fields, tx_active_idx        : frame handed to transmitter
//   mb_pending, mb_wr_err, mb_done,
//   mb_aborted, mb_failed                       : mailbox status
// ---------------------------------------------------------------------------
interface can_tx_mailbox_sched_if #(
  parameter int NUM_MB = 4,
  parameter int IDX_W  = $clog2(NUM_MB)
);
  logic              mb_wr_en;
  logic [IDX_W-1:0]  mb_wr_idx;
  logic              mb_wr_ide;
  logic [10:0]       mb_wr_id_std;
  logic [17:0]       mb_wr_id_ext;
  logic              mb_wr_rtr;
  logic [3:0]        mb_wr_dlc;
  logic [63:0]       mb_wr_data;
  logic [NUM_MB-1:0] mb_abort;
  logic              bus_idle;
  logic              tx_done;
  logic              tx_arb_lost;
  logic              tx_error;

  logic              tx_start;
  logic              tx_ide;
  logic [10:0]       tx_id_std;
  logic [17:0]       tx_id_ext;
  logic              tx_rtr;
  logic [3:0]        tx_dlc;
  logic [63:0]       tx_data;
  logic [IDX_W-1:0]  tx_active_idx;
  logic [NUM_MB-1:0] mb_pending;
  logic              mb_wr_err;
  logic [NUM_MB-1:0] mb_done;
  logic [NUM_MB-1:0] mb_aborted;
  logic [NUM_MB-1:0] mb_failed;

  modport master (
    output mb_wr_en, mb_wr_idx, mb_wr_ide, mb_wr_id_std, mb_wr_id_ext,
           mb_wr_rtr, mb_wr_dlc, mb_wr_data, mb_abort,
           bus_idle, tx_done, tx_arb_lost, tx_error,
    input  tx_start, tx_ide, tx_id_std, tx_id_ext, tx_rtr, tx_dlc, tx_data,
           tx_active_idx, mb_pending, mb_wr_err, mb_done, mb_aborted, mb_failed
  );

  modport slave (
    input  mb_wr_en, mb_wr_idx, mb_wr_ide, mb_wr_id_std, mb_wr_id_ext,
           mb_wr_rtr, mb_wr_dlc, mb_wr_data, mb_abort,
           bus_idle, tx_done, tx_arb_lost, tx_error,
    output tx_start, tx_ide, tx_id_std, tx_id_ext, tx_rtr, tx_dlc, tx_data,
           tx_active_idx, mb_pending, mb_wr_err, mb_done, mb_aborted, mb_failed
  );
endinterface

// File: rtl/can_tx_mailbox_sched.sv
// ---------------------------------------------------------------------------
// can_tx_mailbox_sched
// Multi-mailbox CAN transmit scheduler. Holds NUM_MB frames, picks the
// pending one that would win bus arbitration (lowest 32-bit key, lowest
// index on ties) and hands it to can_transmitter via tx_start / handshake.
// Ports:
//   clk  : core clock
//   rst  : asynchronous reset, active-high
//   bus  : can_tx_mailbox_sched_if.slave (write port, aborts, handshake,
//          frame outputs, mailbox status)
// Build option:
//   CAN_TXMB_RETRY_LIMIT_EN : when defined, a mailbox whose retry counter
//   reaches MAX_RETRY on tx_error is dropped and mb_failed pulses; when
//   undefined, retries are unlimited and mb_failed is tied to 0.
// ---------------------------------------------------------------------------
module can_tx_mailbox_sched #(
  parameter int NUM_MB    = 4,
  parameter int IDX_W     = $clog2(NUM_MB),
  parameter int MAX_RETRY = 3
) (
  input logic                    clk,
  input logic                    rst,
  can_tx_mailbox_sched_if.slave  bus
);

  typedef struct packed {
    logic        ide;
    logic [10:0] id_std;
    logic [17:0] id_ext;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
  } frame_t;

  typedef enum logic [1:0] {S_IDLE, S_SELECT, S_START, S_ACTIVE} state_t;

  // Lower key wins arbitration; mirrors the on-wire bit order (SRR/IDE
  // recessive for extended frames, so a std frame beats an equal-base ext).
  function automatic logic [31:0] arb_key(input frame_t f);
    if (f.ide) return {f.id_std, 2'b11, f.id_ext, f.rtr};
    else       return {f.id_std, f.rtr, 1'b0, 19'b0};
  endfunction

  frame_t            mb_q [NUM_MB];
  frame_t            wr_frame;
  frame_t            tx_q, tx_d;
  state_t            state_q, state_d;
  logic [NUM_MB-1:0] pending_q, pending_d;
  logic [NUM_MB-1:0] done_q, done_d;
  logic [NUM_MB-1:0] aborted_q, aborted_d;
  logic [IDX_W-1:0]  act_q, act_d;
  logic              abort_flag_q, abort_flag_d;
  logic              wr_err_q, wr_err_d;
  logic              wr_accept;
  logic              wr_idx_ok;
  logic              active_busy;
  logic              abort_now;
  logic              win_found;
  logic [IDX_W-1:0]  win_idx;
  logic [31:0]       win_key;
`ifdef CAN_TXMB_RETRY_LIMIT_EN
  logic [3:0]        retry_q [NUM_MB];
  logic [3:0]        retry_d [NUM_MB];
  logic [NUM_MB-1:0] failed_q, failed_d;
`endif

  assign wr_frame = '{ide: bus.mb_wr_ide, id_std: bus.mb_wr_id_std,
                      id_ext: bus.mb_wr_id_ext, rtr: bus.mb_wr_rtr,
                      dlc: bus.mb_wr_dlc, data: bus.mb_wr_data};
  assign wr_idx_ok = int'(bus.mb_wr_idx) < NUM_MB;

  // Arbitration winner among pending mailboxes not being aborted this cycle.
  // Strict less-than while scanning upward keeps the lowest index on ties.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_key   = '1;
    for (int i = 0; i < NUM_MB; i++) begin
      if (pending_q[i] && !bus.mb_abort[i] &&
          (!win_found || arb_key(mb_q[i]) < win_key)) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
        win_key   = arb_key(mb_q[i]);
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned (which would infer a latch); blocking '=' is used here
  // and '<=' only in the clocked blocks.
  always_comb begin
    state_d      = state_q;
    pending_d    = pending_q;
    tx_d         = tx_q;
    act_d        = act_q;
    abort_flag_d = abort_flag_q;
    done_d       = '0;
    aborted_d    = '0;
    wr_err_d     = 1'b0;
    wr_accept    = 1'b0;
    active_busy  = (state_q == S_START) || (state_q == S_ACTIVE);
    abort_now    = abort_flag_q | bus.mb_abort[act_q];
`ifdef CAN_TXMB_RETRY_LIMIT_EN
    retry_d      = retry_q;
    failed_d     = '0;
`endif

    // Host write: only into an empty mailbox that is not being aborted.
    if (bus.mb_wr_en) begin
      if (wr_idx_ok && !pending_q[bus.mb_wr_idx] && !bus.mb_abort[bus.mb_wr_idx]) begin
        wr_accept                = 1'b1;
        pending_d[bus.mb_wr_idx] = 1'b1;
      end else begin
        wr_err_d = 1'b1;
      end
    end

    // Aborts of pending mailboxes that are not on the bus take effect at once;
    // the mailbox on the bus is resolved by its handshake below.
    for (int i = 0; i < NUM_MB; i++) begin
      if (pending_q[i] && bus.mb_abort[i] && !(active_busy && act_q == IDX_W'(i))) begin
        pending_d[i] = 1'b0;
        aborted_d[i] = 1'b1;
`ifdef CAN_TXMB_RETRY_LIMIT_EN
        retry_d[i]   = '0;
`endif
      end
    end

    case (state_q)
      S_IDLE: begin
        if (|pending_q && bus.bus_idle) state_d = S_SELECT;
      end
      S_SELECT: begin
        if (win_found) begin
          tx_d         = mb_q[win_idx];
          act_d        = win_idx;
          abort_flag_d = 1'b0;
          state_d      = S_START;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bus.mb_abort[act_q]) abort_flag_d = 1'b1;
        state_d = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (bus.mb_abort[act_q]) abort_flag_d = 1'b1;
        if (bus.tx_done) begin
          // A successful frame wins over a late abort request.
          pending_d[act_q] = 1'b0;
          done_d[act_q]    = 1'b1;
          abort_flag_d     = 1'b0;
`ifdef CAN_TXMB_RETRY_LIMIT_EN
          retry_d[act_q]   = '0;
`endif
          state_d = S_IDLE;
        end else if (bus.tx_error || bus.tx_arb_lost) begin
          if (abort_now) begin
            pending_d[act_q] = 1'b0;
            aborted_d[act_q] = 1'b1;
`ifdef CAN_TXMB_RETRY_LIMIT_EN
            retry_d[act_q]   = '0;
`endif
          end
`ifdef CAN_TXMB_RETRY_LIMIT_EN
          else if (bus.tx_error) begin
            if (int'(retry_q[act_q]) + 1 >= MAX_RETRY) begin
              pending_d[act_q] = 1'b0;
              failed_d[act_q]  = 1'b1;
              retry_d[act_q]   = '0;
            end else if (retry_q[act_q] != 4'hF) begin
              retry_d[act_q] = retry_q[act_q] + 4'd1;
            end
          end
`endif
          abort_flag_d = 1'b0;
          state_d      = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pending_q    <= '0;
      done_q       <= '0;
      aborted_q    <= '0;
      tx_q         <= '0;
      act_q        <= '0;
      abort_flag_q <= 1'b0;
      wr_err_q     <= 1'b0;
`ifdef CAN_TXMB_RETRY_LIMIT_EN
      failed_q     <= '0;
      for (int i = 0; i < NUM_MB; i++) retry_q[i] <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pending_q    <= pending_d;
      done_q       <= done_d;
      aborted_q    <= aborted_d;
      tx_q         <= tx_d;
      act_q        <= act_d;
      abort_flag_q <= abort_flag_d;
      wr_err_q     <= wr_err_d;
`ifdef CAN_TXMB_RETRY_LIMIT_EN
      failed_q     <= failed_d;
      retry_q      <= retry_d;
`endif
    end
  end

  // NOTE: mailbox payload storage is deliberately not reset; a mailbox is
  // only read while its (reset) pending bit is set, so stale data is harmless.
  always_ff @(posedge clk) begin
    if (wr_accept) mb_q[bus.mb_wr_idx] <= wr_frame;
  end

  assign bus.tx_start      = (state_q == S_START);
  assign bus.tx_ide        = tx_q.ide;
  assign bus.tx_id_std     = tx_q.id_std;
  assign bus.tx_id_ext     = tx_q.id_ext;
  assign bus.tx_rtr        = tx_q.rtr;
  assign bus.tx_dlc        = tx_q.dlc;
  assign bus.tx_data       = tx_q.data;
  assign bus.tx_active_idx = act_q;
  assign bus.mb_pending    = pending_q;
  assign bus.mb_wr_err     = wr_err_q;
  assign bus.mb_done       = done_q;
  assign bus.mb_aborted    = aborted_q;
`ifdef CAN_TXMB_RETRY_LIMIT_EN
  assign bus.mb_failed     = failed_q;
`else
  assign bus.mb_failed     = '0;
`endif

endmodule
